// File: rtl/piso_shift_4bit.sv
// Parallel-in, serial-out shifter with valid/ready serial output.
// Captures a word on ld, then emits one bit per accepted beat; back-to-back loads on the last beat.
module piso_shift_4bit #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             sval,
  input  logic             srdy,
  output logic             busy,
  output logic             done,
  output logic             ld_drop
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              done_q, done_d;
  logic              ld_drop_q, ld_drop_d;

  logic beat;
  logic last_beat;

  assign beat      = (state_q == StShift) && srdy;
  assign last_beat = beat && (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    done_d    = 1'b0;
    ld_drop_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld) begin
          shreg_d = d;
          q_d     = d;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (beat) begin
          shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          cnt_d   = cnt_q + CntW'(1);
        end
        if (last_beat) begin
          done_d = 1'b1;
          // A load on the final beat chains the next word with no idle gap.
          if (ld) begin
            shreg_d = d;
            q_d     = d;
            cnt_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (ld) begin
          ld_drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      done_q    <= 1'b0;
      ld_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      done_q    <= done_d;
      ld_drop_q <= ld_drop_d;
    end
  end

  assign q       = q_q;
  assign sout    = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign sval    = (state_q == StShift);
  assign busy    = (state_q == StShift);
  assign done    = done_q;
  assign ld_drop = ld_drop_q;

endmodule

// File: tb/tb_piso_shift_4bit.sv
// Bench for piso_shift_4bit: LSB-first and MSB-first instances share stimulus and are
// checked every cycle against a word/index model, plus directed stream checks.
module tb_piso_shift_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d;
  logic         ld;
  logic         srdy;

  logic [W-1:0] q_l, q_m;
  logic         sout_l, sout_m, sval_l, sval_m, busy_l, busy_m;
  logic         done_l, done_m, drop_l, drop_m;

  piso_shift_4bit #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .d(d), .ld(ld), .q(q_l), .sout(sout_l), .sval(sval_l),
    .srdy(srdy), .busy(busy_l), .done(done_l), .ld_drop(drop_l)
  );

  piso_shift_4bit #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .d(d), .ld(ld), .q(q_m), .sout(sout_m), .sval(sval_m),
    .srdy(srdy), .busy(busy_m), .done(done_m), .ld_drop(drop_m)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: word being sent, index of the next bit in transmission order.
  logic         m_busy;
  logic [W-1:0] m_word, m_q;
  int           m_idx;
  logic         m_done, m_drop;

  logic [15:0]  strm_l, strm_m;
  int           slen;
  int           n_done, n_drop;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_word = '0; m_q = '0; m_idx = 0; m_done = 1'b0; m_drop = 1'b0;
  endtask

  task automatic compare_all();
    logic el, em;
    el = m_busy ? m_word[m_idx] : 1'b0;
    em = m_busy ? m_word[W-1-m_idx] : 1'b0;
    checkw("q_lsb", 16'(q_l), 16'(m_q));
    checkw("q_msb", 16'(q_m), 16'(m_q));
    check1("sout_lsb", sout_l, el);
    check1("sout_msb", sout_m, em);
    check1("sval_lsb", sval_l, m_busy);
    check1("sval_msb", sval_m, m_busy);
    check1("busy_lsb", busy_l, m_busy);
    check1("busy_msb", busy_m, m_busy);
    check1("done_lsb", done_l, m_done);
    check1("done_msb", done_m, m_done);
    check1("drop_lsb", drop_l, m_drop);
    check1("drop_msb", drop_m, m_drop);
  endtask

  task automatic clear_stream();
    strm_l = '0; strm_m = '0; slen = 0; n_done = 0; n_drop = 0;
  endtask

  task automatic step(input logic i_ld, input logic [W-1:0] i_d, input logic i_srdy);
    logic beat, last;
    ld = i_ld; d = i_d; srdy = i_srdy;
    if (sval_l && srdy && slen < 16) begin
      strm_l[slen] = sout_l;
      strm_m[slen] = sout_m;
      slen++;
    end
    @(posedge clk);
    beat   = m_busy && i_srdy;
    last   = beat && (m_idx == W - 1);
    m_done = last;
    m_drop = m_busy && i_ld && !last;
    if (!m_busy) begin
      if (i_ld) begin
        m_word = i_d; m_q = i_d; m_idx = 0; m_busy = 1'b1;
      end
    end else if (last) begin
      if (i_ld) begin
        m_word = i_d; m_q = i_d; m_idx = 0;
      end else begin
        m_busy = 1'b0;
      end
    end else if (beat) begin
      m_idx++;
    end
    #1;
    compare_all();
    if (done_l) n_done++;
    if (drop_l) n_drop++;
  endtask

  initial begin
    rst = 1'b0; ld = 1'b0; d = '0; srdy = 1'b0;
    model_reset();
    clear_stream();
    #2;
    compare_all();
    #10 rst = 1'b1;

    // Plain word, LSB first: 1010 -> 0,1,0,1.
    clear_stream();
    step(1'b1, 4'b1010, 1'b1);
    repeat (4) step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    checkw("stream_1010", 16'(strm_l[3:0]), 16'(4'b1010));
    checkw("done_cnt_1010", 16'(n_done), 16'd1);

    // Backpressure after the first beat.
    clear_stream();
    step(1'b1, 4'b0011, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    repeat (3) step(1'b0, 4'b0000, 1'b0);
    check1("stall_sout", sout_l, 1'b1);
    repeat (3) step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    checkw("stream_0011", 16'(strm_l[3:0]), 16'(4'b0011));
    checkw("done_cnt_0011", 16'(n_done), 16'd1);

    // Load during the second beat is dropped.
    clear_stream();
    step(1'b1, 4'b0101, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    checkw("q_hold_0101", 16'(q_l), 16'(4'b0101));
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    checkw("stream_0101", 16'(strm_l[3:0]), 16'(4'b0101));
    checkw("drop_cnt_0101", 16'(n_drop), 16'd1);

    // Back-to-back words: load on the last-beat edge.
    clear_stream();
    step(1'b1, 4'b1001, 1'b1);
    repeat (3) step(1'b0, 4'b0000, 1'b1);
    step(1'b1, 4'b0110, 1'b1);
    check1("b2b_sval", sval_l, 1'b1);
    repeat (4) step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    checkw("stream_b2b", 16'(strm_l[7:0]), 16'(8'b0110_1001));
    checkw("done_cnt_b2b", 16'(n_done), 16'd2);
    checkw("drop_cnt_b2b", 16'(n_drop), 16'd0);

    // Asynchronous reset during the third beat.
    clear_stream();
    step(1'b1, 4'b1100, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step(1'b0, 4'b0000, 1'b1);
    checkw("done_cnt_rst", 16'(n_done), 16'd0);

    // MSB-first instance: 1000 -> 1,0,0,0.
    clear_stream();
    step(1'b1, 4'b1000, 1'b1);
    repeat (4) step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    checkw("stream_msb_1000", 16'(strm_m[3:0]), 16'(4'b0001));
    checkw("done_cnt_msb", 16'(n_done), 16'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) == 0, W'($urandom), ($urandom % 4) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_shift_4bit.md
Name: piso_shift_4bit

Overview:
- Parallel-in, serial-out shifter. It is the unload end of the 4-bit register path: it captures a 4-bit word on a load strobe, then shifts it out one bit per accepted beat over a valid/ready serial interface.
- It sits between the datapath register outputs and any single-bit consumer, such as a serial link or a bit-serial ALU.
- It signals completion and refuses new loads while busy.

Parameters:
- WIDTH, 4, number of bits per word (must be >= 2).
- LSB_FIRST, 1, 1 = bit 0 is shifted out first; 0 = bit WIDTH-1 is shifted out first.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 forces the reset state immediately.
- d  in  WIDTH  parallel data word.
- ld  in  1  load strobe; sampled on the rising edge of clk.
- q  out  WIDTH  snapshot of the last accepted word; held until the next accepted load.
- sout  out  1  serial data bit, valid when sval=1.
- sval  out  1  serial valid.
- srdy  in  1  downstream ready; a beat transfers on a clk edge with sval=1 and srdy=1.
- busy  out  1  1 while a word is being shifted (state SHIFT).
- done  out  1  one-cycle pulse after the final bit of a word transfers.
- ld_drop  out  1  one-cycle pulse when ld=1 is ignored.

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, shreg=0, cnt=0, q=0, sout=0, sval=0, busy=0, done=0, ld_drop=0. Reset applied mid-shift aborts the word: no done pulse, and the remaining bits are lost.
- Register map:
  - shreg: WIDTH bits.
  - cnt: ceil(log2(WIDTH)) bits, counts accepted beats 0..WIDTH-1.
  - sout = shreg[0] if LSB_FIRST, else shreg[WIDTH-1]. It is driven from registered state only and has no combinational path from d.
  - sval = busy = (state==SHIFT).
- IDLE state:
  - ld=1: shreg<=d, q<=d, cnt<=0, state<=SHIFT.
  - The first bit is visible with sval=1 in the cycle after the loading edge (1-cycle load latency).
  - ld=0: no change.
- SHIFT state, on each beat (sval & srdy):
  - Shift shreg by one toward the output end (right if LSB_FIRST, else left), filling with 0.
  - cnt<=cnt+1.
- SHIFT state, srdy=0: shreg, cnt and sout hold; sval stays 1. Backpressure may last any number of cycles.
- Last beat (beat with cnt==WIDTH-1):
  - done<=1 for exactly one cycle.
  - If ld=1 on the same edge: load the new word (shreg<=d, q<=d, cnt<=0) and stay in SHIFT. Back-to-back words have no idle gap, and ld_drop does not pulse.
  - Otherwise: state<=IDLE, so sval=0 the next cycle.
- ld=1 in SHIFT other than on the last-beat edge: ignored, with ld_drop<=1 for one cycle. shreg, q and cnt are unaffected.
- Throughput: WIDTH cycles per word with srdy held 1. Words are continuous when ld is presented on each last-beat edge.
- cnt never exceeds WIDTH-1. No wrap occurs because cnt resets on load.
- done and ld_drop are registered pulses and are never high for two consecutive cycles from a single event.

Test Plan:
- Reset, then ld=1 with d=4'b1010 and srdy=1 held (LSB_FIRST=1):
  - sout=0,1,0,1 on 4 consecutive cycles with sval=1 and q=4'b1010.
  - done pulses one cycle after the 4th beat; busy=0 afterwards.
- d=4'b0011 loaded, srdy=0 for 3 cycles after the first beat, then srdy=1:
  - sout holds 1 and sval stays 1 during the stall.
  - Full sequence 1,1,0,0 is delivered; done fires only after the 4th accepted beat.
- ld=1 with d=4'b1111 during the 2nd beat of word 4'b0101:
  - ld_drop pulses once; q stays 4'b0101; output stream 1,0,1,0 is unchanged.
- Back-to-back: load 4'b1001, then ld=1 with d=4'b0110 on the last-beat edge:
  - Stream 1,0,0,1,0,1,1,0 with sval continuously 1 for 8 cycles.
  - done pulses twice; ld_drop stays 0.
- rst=0 asserted asynchronously mid-cycle during the 3rd beat of 4'b1100:
  - All outputs go to 0 immediately, with no done pulse.
  - After rst=1, the block idles until the next ld.
- LSB_FIRST=0, d=4'b1000, srdy=1: sout=1,0,0,0, then done.
